// File: rtl/key_debounce.sv
// Push-button conditioner: two-flop synchronizer plus saturating debounce
// counter per channel, with registered one-cycle press/release strobes.
module key_debounce #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_WIDTH       = 20,
    parameter int IDLE_LEVEL      = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] key_in,
    output logic [WIDTH-1:0] key_db,
    output logic [WIDTH-1:0] key_press,
    output logic [WIDTH-1:0] key_release
);

    localparam logic IDLE = (IDLE_LEVEL != 0);
    localparam logic [CNT_WIDTH-1:0] TERM = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0]     sync1_q;
    logic [WIDTH-1:0]     sync2_q;
    logic [WIDTH-1:0]     db_q;
    logic [WIDTH-1:0]     db_d;
    logic [WIDTH-1:0]     press_q;
    logic [WIDTH-1:0]     press_d;
    logic [WIDTH-1:0]     rel_q;
    logic [WIDTH-1:0]     rel_d;
    logic [CNT_WIDTH-1:0] cnt_q [WIDTH];
    logic [CNT_WIDTH-1:0] cnt_d [WIDTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= {WIDTH{IDLE}};
            sync2_q <= {WIDTH{IDLE}};
            db_q    <= {WIDTH{IDLE}};
            press_q <= '0;
            rel_q   <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= key_in;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // A single stable sample back at the accepted level restarts the count.
    always_comb begin
        db_d    = db_q;
        press_d = '0;
        rel_d   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == TERM) begin
                    db_d[i] = sync2_q[i];
                    if (sync2_q[i] != IDLE) begin
                        press_d[i] = 1'b1;
                    end else begin
                        rel_d[i] = 1'b1;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign key_db      = db_q;
    assign key_press   = press_q;
    assign key_release = rel_q;

endmodule
